// File: rtl/mmio_sig_collector.sv
// mmio_sig_collector: MMIO signature decoder with record FIFO and run control.
// Optional MMIO_SIG_TAINT_EN stores the write-data taint shadow per record.
module mmio_sig_collector #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CYC_W      = 32,
    parameter int STOP_DRAIN = 50,
    parameter logic [ADDR_W-1:0] ADDR_STOP       = ADDR_W'(32'h6000_0000),
    parameter logic [ADDR_W-1:0] ADDR_TRAP       = ADDR_W'(32'h6000_0008),
    parameter logic [ADDR_W-1:0] ADDR_REG_DUMP   = ADDR_W'(32'h6000_0010),
    parameter logic [ADDR_W-1:0] ADDR_FREG_DUMP  = ADDR_W'(32'h6000_0018),
    parameter logic [ADDR_W-1:0] ADDR_REG_STREAM = ADDR_W'(32'h6000_0020)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mmio_req_i,
    input  logic              mmio_we_i,
    input  logic [ADDR_W-1:0] mmio_addr_i,
    input  logic [DATA_W-1:0] mmio_wdata_i,
    input  logic [DATA_W-1:0] mmio_wdata_t0_i,
    input  logic [CYC_W-1:0]  simlen_i,
    input  logic              dontstop_trap_i,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [2:0]        rec_kind_o,
    output logic [IDX_W-1:0]  rec_idx_o,
    output logic [DATA_W-1:0] rec_data_o,
    output logic [DATA_W-1:0] rec_taint_o,
    output logic              stop_req_o,
    output logic              trap_seen_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [CYC_W-1:0]  cycle_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic run, wr, h_int, h_freg, h_stream, h_stop, h_trap, hit, stop_go, limit;
    logic push, pop, full, empty;
    logic [2:0] kind;
    logic [CYC_W-1:0] drain_cnt;
    logic [IDX_W-1:0] idx [8];
    logic [AW:0] wp, rp;
    logic [2:0] kind_m [FIFO_DEPTH];
    logic [IDX_W-1:0] idx_m [FIFO_DEPTH];
    logic [DATA_W-1:0] data_m [FIFO_DEPTH];
    assign wr       = mmio_req_i && mmio_we_i && run;
    assign h_int    = wr && mmio_addr_i == ADDR_REG_DUMP;
    assign h_freg   = wr && mmio_addr_i == ADDR_FREG_DUMP;
    assign h_stream = wr && mmio_addr_i == ADDR_REG_STREAM;
    assign h_stop   = wr && mmio_addr_i == ADDR_STOP;
    assign h_trap   = mmio_req_i && run && mmio_addr_i == ADDR_TRAP;
    assign hit      = h_int || h_freg || h_stream || h_stop || h_trap;
    assign kind     = h_freg ? 3'd1 : h_stream ? 3'd2 : h_stop ? 3'd3 : h_trap ? 3'd4 : 3'd0;
    assign stop_go  = h_stop || (h_trap && !dontstop_trap_i);
    assign limit    = simlen_i != '0 && cycle_o == simlen_i - CYC_W'(1);
    assign empty    = wp == rp;
    assign full     = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign pop      = !empty && rec_ready_i;
    assign push     = hit && (!full || pop);
    always_ff @(posedge clk_i)
        if (rst_i) state <= RUN;
        else state <= state_n;
    always_comb begin
        state_n = state;
        if (state == RUN && stop_go) state_n = DRAIN;
        if (state == DRAIN && drain_cnt == '0) state_n = DONE;
        if (limit) state_n = DONE;
    end
    always_comb begin
        run    = state == RUN;
        done_o = state == DONE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp          <= '0;
            rp          <= '0;
            drain_cnt   <= '0;
            stop_req_o  <= 1'b0;
            trap_seen_o <= 1'b0;
            overflow_o  <= 1'b0;
            cycle_o     <= '0;
            for (int k = 0; k < 8; k++) idx[k] <= k == 0 ? IDX_W'(1) : '0;
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            if (hit) idx[kind] <= idx[kind] + IDX_W'(1);
            if (hit && full && !pop) overflow_o <= 1'b1;
            if (stop_go) stop_req_o <= 1'b1;
            if (h_trap) trap_seen_o <= 1'b1;
            if (stop_go) drain_cnt <= CYC_W'(STOP_DRAIN);
            else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - CYC_W'(1);
            if (state != DONE && cycle_o != '1) cycle_o <= cycle_o + CYC_W'(1);
        end
    end
    always_ff @(posedge clk_i)
        if (push) begin
            kind_m[wp[AW-1:0]] <= kind;
            idx_m[wp[AW-1:0]]  <= idx[kind];
            data_m[wp[AW-1:0]] <= mmio_wdata_i;
        end
    assign rec_valid_o = !empty;
    assign rec_kind_o  = kind_m[rp[AW-1:0]];
    assign rec_idx_o   = idx_m[rp[AW-1:0]];
    assign rec_data_o  = data_m[rp[AW-1:0]];
`ifdef MMIO_SIG_TAINT_EN
    logic [DATA_W-1:0] taint_m [FIFO_DEPTH];
    always_ff @(posedge clk_i)
        if (push) taint_m[wp[AW-1:0]] <= mmio_wdata_t0_i;
    assign rec_taint_o = taint_m[rp[AW-1:0]];
`else
    logic unused_taint;
    assign unused_taint = ^mmio_wdata_t0_i;
    assign rec_taint_o  = '0;
`endif
endmodule

// File: doc/mmio_sig_collector.md
Name: mmio_sig_collector

Overview:
- Synthesizable signature decoder on the tiny-SoC MMIO write port, upstream of the simulation logger.
- Watches MMIO writes to the stop, trap, int-reg-dump, float-reg-dump and reg-stream addresses, and tags each hit with a kind and a running index.
- Buffers tagged records, with their taint shadow, in a FIFO drained over a valid/ready stream.
- Owns run control: stop/trap latching, post-stop drain countdown, cycle-limit termination.

Parameters:
- ADDR_W, 32, MMIO address width
- DATA_W, 64, MMIO write-data width
- IDX_W, 8, per-kind record index width
- FIFO_DEPTH, 8, record FIFO entries; power of two, >=2
- CYC_W, 32, cycle counter / limit width
- STOP_DRAIN, 50, cycles run after a stop or trap before done
- ADDR_STOP, 32'h60000000, stop-signature address
- ADDR_TRAP, 32'h60000008, trap-signature address
- ADDR_REG_DUMP, 32'h60000010, integer register dump address
- ADDR_FREG_DUMP, 32'h60000018, float register dump address
- ADDR_REG_STREAM, 32'h60000020, register stream address

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mmio_req_i  in  1  MMIO request
- mmio_we_i  in  1  MMIO write enable
- mmio_addr_i  in  ADDR_W  MMIO address
- mmio_wdata_i  in  DATA_W  MMIO write data
- mmio_wdata_t0_i  in  DATA_W  write-data taint shadow
- simlen_i  in  CYC_W  cycle limit; 0 = unlimited
- dontstop_trap_i  in  1  1 = a trap does not stop the run
- rec_valid_o  out  1  record available
- rec_ready_i  in  1  consumer accepts record
- rec_kind_o  out  3  0 INT, 1 FREG, 2 STREAM, 3 STOP, 4 TRAP
- rec_idx_o  out  IDX_W  per-kind index
- rec_data_o  out  DATA_W  captured write data
- rec_taint_o  out  DATA_W  captured taint
- stop_req_o  out  1  stop or trap latched (sticky)
- trap_seen_o  out  1  any trap access seen (sticky)
- done_o  out  1  run finished (sticky)
- overflow_o  out  1  record dropped because the FIFO was full (sticky)
- cycle_o  out  CYC_W  cycles since reset release

Behaviour:
- Reset: all outputs 0, FIFO empty, state RUN, cycle_o=0. INT index=1; FREG, STREAM, STOP and TRAP indices=0.
- Decode, combinational on the current cycle:
  - hit = mmio_req_i && full-width address match.
  - STOP, INT, FREG and STREAM additionally require mmio_we_i.
  - TRAP fires on a read or a write.
- Decode is active only in state RUN; in DRAIN and DONE every hit is ignored.
- Each accepted hit pushes one record {kind, idx, data, taint} and increments that kind's index, modulo 2^IDX_W.
- If the FIFO is full and no pop happens that cycle:
  - the record is dropped;
  - the index still increments;
  - overflow_o sets.
- A simultaneous push and pop on a full FIFO succeeds.
- Stream: rec_* outputs come directly from the FIFO head.
  - rec_valid_o = FIFO not empty; pop on rec_valid_o && rec_ready_i.
  - Head fields stay stable while valid and not ready.
  - Push-to-valid latency is 1 cycle.
- State machine {RUN, DRAIN, DONE}:
  - RUN -> DRAIN when a STOP hit occurs, or a TRAP hit with dontstop_trap_i=0. stop_req_o sets on the same edge and a drain counter loads STOP_DRAIN.
  - TRAP hit with dontstop_trap_i=1: trap_seen_o sets, a TRAP record is pushed, state stays RUN.
  - DRAIN: the counter decrements each cycle; at counter==0 -> DONE. done_o therefore rises STOP_DRAIN+1 edges after the edge that sampled the stop.
  - Any state -> DONE when simlen_i!=0 and cycle_o==simlen_i-1. This takes priority over a stop hit in the same cycle; the stop record is still pushed.
  - DONE is terminal until rst_i. cycle_o freezes in DONE.
- cycle_o increments every cycle outside DONE and saturates at all-ones.
- The FIFO keeps draining in DONE.
- rst_i mid-run: everything returns to reset values next edge, the FIFO is flushed, and in-flight records are lost.

Optional Feature:
- Macro: MMIO_SIG_TAINT_EN.
- Defined: mmio_wdata_t0_i is stored per record and driven on rec_taint_o.
- Undefined: no taint storage is instantiated, rec_taint_o is tied to 0, and mmio_wdata_t0_i is ignored.

Test Plan:
- Int dump: 3 writes to 0x60000010 with data 0xA, 0xB, 0xC, rec_ready_i=1 -> INT records with idx 1, 2, 3 and matching data, each valid 1 cycle after its write.
- Back-pressure overflow: rec_ready_i=0, FIFO_DEPTH+1 stream writes -> first 8 records held (idx 0..7), overflow_o=1 after the 9th. Raising ready then yields idx 0..7 and nothing else.
- Stop drain: stop write sampled at cycle 20 -> stop_req_o=1 from 21, done_o=1 at 71. A dump write at cycle 30 produces no record.
- Trap: dontstop_trap_i=0 with a read of 0x60000008 -> TRAP record and DRAIN. Repeat with dontstop_trap_i=1 -> trap_seen_o=1, state stays RUN, later dumps still recorded.
- Cycle limit: simlen_i=100 with a stop hit at cycle 99 -> done_o=1 right after cycle 99, STOP record present, no drain. simlen_i=0 -> never done without a stop.
- Taint: with MMIO_SIG_TAINT_EN, write data 0x5 with taint 0xF0 -> rec_taint_o=0xF0. Without the macro -> rec_taint_o=0.
